// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU command engine.
package alu_seq_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_ADD  = 3'd2;
    localparam op_t OP_SUB  = 3'd3;
    localparam op_t OP_ALU  = 3'd4;
    localparam op_t OP_ACC3 = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

endpackage

// File: rtl/alu_seq_datapath.sv
// Combinational operator datapath; carry logic exists only when ALU_SEQ_CARRY_EN is defined.
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         illegal
`ifdef ALU_SEQ_CARRY_EN
    ,
    output logic         carry
`endif
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // ACC3 returns its first term (a+b); the engine accumulates the rest over EXEC.
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_ALU:  result = sum + diff;
            OP_ACC3: result = sum;
            default: illegal = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_CARRY_EN
    logic [W:0] sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign carry   = (op == OP_ADD) ? sum_ext[W] :
                     (op == OP_SUB) ? (a < b)    : 1'b0;
`endif

endmodule

// File: rtl/alu_seq_engine.sv
// Valid/ready command front-end: single-cycle ops respond next cycle, ACC3 after 3 cycles.
// Optional rsp_carry output is built when ALU_SEQ_CARRY_EN is defined.
module alu_seq_engine
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic [2:0]   rsp_op,
    output logic         rsp_err
`ifdef ALU_SEQ_CARRY_EN
    ,
    output logic         rsp_carry
`endif
);

    state_t       state_q, state_d;
    logic         cnt_q, cnt_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] acc_q, acc_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_result_q, rsp_result_d;
    op_t          rsp_op_q, rsp_op_d;
    logic         rsp_err_q, rsp_err_d;

    op_t          dp_op;
    logic [W-1:0] dp_a;
    logic [W-1:0] dp_b;
    logic [W-1:0] dp_result;
    logic         dp_illegal;

`ifdef ALU_SEQ_CARRY_EN
    logic         rsp_carry_q, rsp_carry_d;
    logic         dp_carry;
`endif

    // In IDLE the datapath sees the incoming command; in EXEC it supplies the ACC3 terms.
    always_comb begin
        dp_op = cmd_op;
        dp_a  = cmd_a;
        dp_b  = cmd_b;
        if (state_q == StExec) begin
            dp_op = cnt_q ? OP_ALU : OP_SUB;
            dp_a  = a_q;
            dp_b  = b_q;
        end
    end

    alu_seq_datapath #(
        .W (W)
    ) u_datapath (
        .op      (dp_op),
        .a       (dp_a),
        .b       (dp_b),
        .result  (dp_result),
        .illegal (dp_illegal)
`ifdef ALU_SEQ_CARRY_EN
        ,
        .carry   (dp_carry)
`endif
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
`ifdef ALU_SEQ_CARRY_EN
        rsp_carry_d  = rsp_carry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a_d      = cmd_a;
                    b_d      = cmd_b;
                    rsp_op_d = cmd_op;
                    if (cmd_op == OP_ACC3) begin
                        acc_d   = dp_result;
                        cnt_d   = 1'b0;
                        state_d = StExec;
                    end else begin
                        rsp_result_d = dp_result;
                        rsp_err_d    = dp_illegal;
`ifdef ALU_SEQ_CARRY_EN
                        rsp_carry_d  = dp_carry;
`endif
                        rsp_valid_d  = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StExec: begin
                if (!cnt_q) begin
                    acc_d = acc_q + dp_result;
                    cnt_d = 1'b1;
                end else begin
                    rsp_result_d = acc_q + dp_result;
                    rsp_err_d    = 1'b0;
`ifdef ALU_SEQ_CARRY_EN
                    rsp_carry_d  = 1'b0;
`endif
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_CARRY_EN
            rsp_carry_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
`ifdef ALU_SEQ_CARRY_EN
            rsp_carry_q  <= rsp_carry_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;
    assign rsp_err    = rsp_err_q;
`ifdef ALU_SEQ_CARRY_EN
    assign rsp_carry  = rsp_carry_q;
`endif

endmodule

// File: tb/tb_alu_seq_engine.sv
// Scoreboard bench for alu_seq_engine; compare carry when ALU_SEQ_CARRY_EN is defined.
module tb_alu_seq_engine;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_op;
    logic         rsp_err;
`ifdef ALU_SEQ_CARRY_EN
    logic         rsp_carry;
`endif

    typedef struct packed {
        logic [W-1:0] result;
        logic [2:0]   op;
        logic         err;
        logic         carry;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    alu_seq_engine #(
        .W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err)
`ifdef ALU_SEQ_CARRY_EN
        ,
        .rsp_carry  (rsp_carry)
`endif
    );

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        e    = '0;
        e.op = op;
        s    = {1'b0, a} + {1'b0, b};
        case (op)
            3'd0: e.result = a & b;
            3'd1: e.result = a | b;
            3'd2: begin e.result = s[W-1:0]; e.carry = s[W]; end
            3'd3: begin e.result = a - b; e.carry = (a < b); end
            3'd4: e.result = a << 1;
            3'd5: e.result = a << 2;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected response, then holds cmd_valid until accepted (bounded).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output bit ok);
        sb.push_back(model(op, a, b));
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        ok        = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({rsp_valid, cmd_ready, rsp_result, rsp_op, rsp_err} !== {1'b0, 1'b1, 8'h00, 3'd0, 1'b0})
            $display("FAIL reset_outputs: got %h want %h",
                     {rsp_valid, cmd_ready, rsp_result, rsp_op, rsp_err}, 14'h1000);
        else passed++;
`ifdef ALU_SEQ_CARRY_EN
        total++;
        if (rsp_carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", rsp_carry);
        else passed++;
`endif
        rst = 1'b0;
        tick();
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b10)
            $display("FAIL reset_release: got %b want 10", {cmd_ready, rsp_valid});
        else passed++;
    endtask

    task automatic test_and();
        bit   ok;
        exp_t e;
        issue(3'd0, 8'hF0, 8'h3C, ok);
        total++;
        if ({ok, rsp_valid, cmd_ready} !== 3'b110)
            $display("FAIL and_latency: got %b want 110", {ok, rsp_valid, cmd_ready});
        else passed++;
        e = sb.pop_front();
        total++;
        if ({rsp_result, rsp_op, rsp_err} !== {e.result, e.op, e.err})
            $display("FAIL and_result: got %h want %h", {rsp_result, rsp_op, rsp_err},
                     {e.result, e.op, e.err});
        else passed++;
        handshake();
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL and_release: got %b want 01", {rsp_valid, cmd_ready});
        else passed++;
    endtask

    task automatic test_add_sub();
        logic [2:0]   ops [2] = '{3'd2, 3'd3};
        logic [W-1:0] as  [2] = '{8'hFF, 8'h05};
        logic [W-1:0] bs  [2] = '{8'h01, 8'h07};
        bit           ok;
        exp_t         e;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], as[i], bs[i], ok);
            e = sb.pop_front();
            total++;
            if ({ok, rsp_valid, rsp_result, rsp_op, rsp_err} !== {2'b11, e.result, e.op, e.err})
                $display("FAIL add_sub_%0d: got %h want %h", i,
                         {ok, rsp_valid, rsp_result, rsp_op, rsp_err},
                         {2'b11, e.result, e.op, e.err});
            else passed++;
`ifdef ALU_SEQ_CARRY_EN
            total++;
            if (rsp_carry !== e.carry)
                $display("FAIL add_sub_carry_%0d: got %b want %b", i, rsp_carry, e.carry);
            else passed++;
`endif
            handshake();
        end
    endtask

    task automatic test_acc3();
        bit   ok;
        exp_t e;
        issue(3'd5, 8'h11, 8'h22, ok);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({ok, rsp_valid, cmd_ready} !== 3'b100)
                $display("FAIL acc3_busy_%0d: got %b want 100", i, {ok, rsp_valid, cmd_ready});
            else passed++;
            tick();
        end
        e = sb.pop_front();
        total++;
        if ({rsp_valid, cmd_ready, rsp_result, rsp_op, rsp_err} !== {2'b10, e.result, e.op, e.err})
            $display("FAIL acc3_result: got %h want %h",
                     {rsp_valid, cmd_ready, rsp_result, rsp_op, rsp_err},
                     {2'b10, e.result, e.op, e.err});
        else passed++;
        handshake();
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL acc3_release: got %b want 1", cmd_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit   ok;
        exp_t e;
        issue(3'd1, 8'h0F, 8'hA0, ok);
        e         = sb.pop_front();
        cmd_op    = 3'd0;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, cmd_ready, rsp_result, rsp_op} !== {2'b10, e.result, e.op})
                $display("FAIL hold_%0d: got %h want %h", i,
                         {rsp_valid, cmd_ready, rsp_result, rsp_op}, {2'b10, e.result, e.op});
            else passed++;
            tick();
        end
        cmd_valid = 1'b0;
        handshake();
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL hold_release: got %b want 01", {rsp_valid, cmd_ready});
        else passed++;
    endtask

    task automatic test_illegal();
        bit   ok;
        exp_t e;
        for (int op = 6; op < 8; op++) begin
            issue(3'(op), 8'h12, 8'h34, ok);
            e = sb.pop_front();
            total++;
            if ({ok, rsp_valid, rsp_result, rsp_op, rsp_err} !== {2'b11, e.result, e.op, e.err})
                $display("FAIL illegal_%0d: got %h want %h", op,
                         {ok, rsp_valid, rsp_result, rsp_op, rsp_err},
                         {2'b11, e.result, e.op, e.err});
            else passed++;
            handshake();
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   seen;
        exp_t e;
        issue(3'd5, 8'h11, 8'h22, ok);
        rst = 1'b1;
        #1;
        sb.delete();
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL midreset_async: got %b want 01", {rsp_valid, cmd_ready});
        else passed++;
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if ({seen, cmd_ready} !== 2'b01)
            $display("FAIL midreset_dropped: got %b want 01", {seen, cmd_ready});
        else passed++;
        issue(3'd2, 8'h01, 8'h02, ok);
        e = sb.pop_front();
        total++;
        if ({ok, rsp_valid, rsp_result, rsp_err} !== {2'b11, e.result, e.err})
            $display("FAIL midreset_add: got %h want %h", {ok, rsp_valid, rsp_result, rsp_err},
                     {2'b11, e.result, e.err});
        else passed++;
        handshake();
    endtask

    task automatic test_back_to_back();
        bit   ok;
        exp_t e;
        int   n;
        rsp_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ok);
            n = 0;
            while (!rsp_valid && n < 10) begin
                tick();
                n++;
            end
            e = sb.pop_front();
            total++;
            if ({ok, rsp_valid, rsp_result, rsp_op, rsp_err} !== {2'b11, e.result, e.op, e.err})
                $display("FAIL b2b_%0d: got %h want %h", i,
                         {ok, rsp_valid, rsp_result, rsp_op, rsp_err},
                         {2'b11, e.result, e.op, e.err});
            else passed++;
`ifdef ALU_SEQ_CARRY_EN
            total++;
            if (rsp_carry !== e.carry)
                $display("FAIL b2b_carry_%0d: got %b want %b", i, rsp_carry, e.carry);
            else passed++;
`endif
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_and();
        test_add_sub();
        test_acc3();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
